// File: rtl/bcd_chain_adjust_ctrl_pkg.sv
// Shared constants and FSM encoding for the multi-byte BCD/ASCII add sequencer.
package bcd_chain_adjust_ctrl_pkg;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_ASCII = 2'b10;
    localparam logic [1:0] MODE_DEC   = 2'b11;

    localparam logic [7:0] ASCII_BIAS = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/bcd_chain_adjust_ctrl_byte_adjust.sv
// Single-byte add with decimal or ASCII adjust; purely combinational.
module bcd_byte_adjust
    import bcd_chain_adjust_ctrl_pkg::*;
#(
    parameter bit ASCII_OUT = 1'b1
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [1:0] mode,
    output logic [7:0] res,
    output logic       carry,
    output logic       af
);

    logic [8:0] raw9;
    logic [4:0] lo5;
    logic [7:0] raw;
    logic       cfr;
    logic       afr;
    logic       ma;
    logic       md;
    logic [3:0] lo_adj;

    assign raw9   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign lo5    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
    assign raw    = raw9[7:0];
    assign cfr    = raw9[8];
    assign afr    = lo5[4];
    assign ma     = afr | (raw[3:0] > 4'd9);
    assign md     = cfr | (raw > 8'h99);
    // Low nibble wraps mod 16, which is exactly the unpacked-digit correction.
    assign lo_adj = raw[3:0] + (ma ? 4'd6 : 4'd0);

    always_comb begin
        res   = raw;
        carry = cfr;
        af    = afr;
        if (mode == MODE_DEC) begin
            res   = raw + (ma ? 8'h06 : 8'h00) + (md ? 8'h60 : 8'h00);
            carry = md;
            af    = ma;
        end else if (mode == MODE_ASCII) begin
            res   = {4'h0, lo_adj} | (ASCII_OUT ? ASCII_BIAS : 8'h00);
            carry = ma;
            af    = ma;
        end
    end

endmodule

// File: rtl/bcd_chain_adjust_ctrl.sv
// Byte-serial sequencer: loads an operand pair, adjusts it, emits the result,
// and chains the carry into the next byte, LSB first.
module bcd_chain_adjust_ctrl
    import bcd_chain_adjust_ctrl_pkg::*;
#(
    parameter int LEN_W     = 5,
    parameter bit ASCII_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic             cin,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             done,
    output logic             cf_out,
    output logic             af_out
);

    state_e           state;
    logic [1:0]       mode_r;
    logic [LEN_W-1:0] rem;
    logic             carry_r;
    logic             af_r;
    logic [7:0]       a_p0;
    logic [7:0]       b_p0;
    logic [7:0]       res;
    logic             res_carry;
    logic             res_af;

    bcd_byte_adjust #(.ASCII_OUT(ASCII_OUT)) u_adj (
        .a     (a_p0),
        .b     (b_p0),
        .cin   (carry_r),
        .mode  (mode_r),
        .res   (res),
        .carry (res_carry),
        .af    (res_af)
    );

    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_EMIT);
    assign done      = (state == ST_DONE);

    // Operand/carry registers carry no reset: they are always written before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            out_byte <= 8'h00;
            out_last <= 1'b0;
            cf_out   <= 1'b0;
            af_out   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        rem     <= len;
                        carry_r <= cin;
                        af_r    <= 1'b0;
                        af_out  <= 1'b0;
                        if (len == '0) begin
                            cf_out <= cin;
                            state  <= ST_DONE;
                        end else begin
                            cf_out <= 1'b0;
                            state  <= ST_LOAD;
                        end
                    end
                end
                // p0: operand pair captured
                ST_LOAD: begin
                    if (in_valid) begin
                        a_p0  <= in_a;
                        b_p0  <= in_b;
                        state <= ST_CALC;
                    end
                end
                // p1: adjusted byte and chained carry captured
                ST_CALC: begin
                    out_byte <= res;
                    out_last <= (rem == LEN_W'(1));
                    carry_r  <= res_carry;
                    af_r     <= res_af;
                    state    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        rem <= rem - LEN_W'(1);
                        if (out_last) begin
                            cf_out <= carry_r;
                            af_out <= af_r;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_chain_adjust_ctrl.sv
// Scoreboard bench: stimulus pushes expected bytes/status, a monitor pops and compares.
module tb_bcd_chain_adjust_ctrl;

    localparam int LEN_W     = 5;
    localparam bit ASCII_OUT = 1'b1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [LEN_W-1:0] len = '0;
    logic             cin = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_a = 8'h00;
    logic [7:0]       in_b = 8'h00;
    logic             out_ready = 1'b1;
    logic             busy, in_ready, out_valid, out_last, done, cf_out, af_out;
    logic [7:0]       out_byte;

    bcd_chain_adjust_ctrl #(.LEN_W(LEN_W), .ASCII_OUT(ASCII_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len), .cin(cin),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .done(done), .cf_out(cf_out), .af_out(af_out)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  exp_q[$];
    logic [1:0]  st_q[$];
    logic        bp_hold = 1'b0;
    logic        bp_rand = 1'b0;
    logic [7:0]  opa[16];
    logic [7:0]  opb[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal works on true decimal values, ASCII on digit values.
    function automatic void model_byte(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                                       input logic c, output logic [7:0] r, output logic co,
                                       output logic af);
        int s, lo, da, db;
        lo = int'(a % 16) + int'(b % 16) + int'(c);
        if (m == 2'b11) begin
            da = int'(a / 16) * 10 + int'(a % 16);
            db = int'(b / 16) * 10 + int'(b % 16);
            s  = da + db + int'(c);
            r  = 8'(((s % 100) / 10) * 16 + (s % 10));
            co = (s >= 100);
            af = (lo > 9);
        end else if (m == 2'b10) begin
            r  = 8'(lo % 10) | (ASCII_OUT ? 8'h30 : 8'h00);
            co = (lo > 9);
            af = (lo > 9);
        end else begin
            s  = int'(a) + int'(b) + int'(c);
            r  = 8'(s % 256);
            co = (s > 255);
            af = (lo > 15);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = bp_hold ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    logic       hold_vld = 1'b0;
    logic [8:0] hold_val;
    always @(negedge clk) begin
        logic [8:0] e;
        logic [1:0] s;
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("out_stable", {out_valid, out_last, out_byte}, {1'b1, hold_val});
            end
            hold_vld = 1'b0;
            if (out_valid) begin
                check("in_ready_in_emit", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", out_byte, e[7:0]);
                        check("out_last", out_last, e[8]);
                    end
                end else begin
                    hold_vld = 1'b1;
                    hold_val = {out_last, out_byte};
                end
            end
            if (done) begin
                if (st_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    s = st_q.pop_front();
                    check("cf_out", cf_out, s[1]);
                    check("af_out", af_out, s[0]);
                end
            end
        end
    end

    // Called aligned at posedge+1; returns aligned at posedge+1 with the block idle.
    task automatic run_op(input logic [1:0] m, input int n, input logic c, input bit poke,
                          input int gapmax);
        logic [7:0] r;
        logic       carry, co, afb, af;
        int         k;
        carry = c;
        af    = 1'b0;
        for (int i = 0; i < n; i++) begin
            model_byte(m, opa[i], opb[i], carry, r, co, afb);
            exp_q.push_back({(i == n - 1), r});
            carry = co;
            af    = afb;
        end
        st_q.push_back({carry, af});
        start = 1'b1; mode = m; len = LEN_W'(n); cin = c;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            start = 1'b1; mode = 2'b00; len = LEN_W'(7); cin = ~c;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gapmax)) @(posedge clk);
            #1;
            in_valid = 1'b1; in_a = opa[i]; in_b = opb[i];
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) check("in_handshake", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_a = 8'($urandom); in_b = 8'($urandom);
        end
        k = 0;
        @(negedge clk);
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("op_finish", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [1:0] m;
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {busy, in_ready, out_valid, out_byte, out_last, done, cf_out, af_out}, 0);
        @(posedge clk); #1;

        // Decimal two-byte, carry chained from 58+67 into 12+34
        opa[0] = 8'h58; opb[0] = 8'h67; opa[1] = 8'h12; opb[1] = 8'h34;
        run_op(2'b11, 2, 1'b0, 1'b0, 0);
        check("t1_cf_hold", cf_out, 0);
        // Decimal 99+99+1
        opa[0] = 8'h99; opb[0] = 8'h99;
        run_op(2'b11, 1, 1'b1, 1'b0, 0);
        check("t2_cf_hold", {cf_out, af_out}, 2'b11);
        // ASCII '7'+'5', '1'+'2'
        opa[0] = 8'h37; opb[0] = 8'h35; opa[1] = 8'h31; opb[1] = 8'h32;
        run_op(2'b10, 2, 1'b0, 1'b0, 0);
        check("t3_cf_hold", cf_out, 0);

        // Backpressure on the first result byte
        bp_hold = 1'b1;
        opa[0] = 8'h58; opb[0] = 8'h67; opa[1] = 8'h12; opb[1] = 8'h34;
        fork
            run_op(2'b11, 2, 1'b0, 1'b0, 0);
            begin
                k = 0;
                @(negedge clk);
                while (!out_valid && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                for (int i = 0; i < 5; i++) begin
                    check("bp_out_valid", out_valid, 1);
                    check("bp_out_byte", out_byte, 8'h25);
                    check("bp_in_ready", in_ready, 0);
                    @(negedge clk);
                end
                bp_hold = 1'b0;
            end
        join

        // Zero-length operation
        st_q.push_back(2'b10);
        start = 1'b1; mode = 2'b11; len = '0; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_done", {done, busy, out_valid}, 3'b110);
        @(negedge clk);
        check("len0_idle", {done, busy, out_valid, cf_out, af_out}, 5'b00010);
        @(posedge clk); #1;

        // Reset while a result byte is held in EMIT
        bp_hold = 1'b1;
        start = 1'b1; mode = 2'b11; len = LEN_W'(2); cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'h58; in_b = 8'h67;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_emit", {out_valid, out_byte}, {1'b1, 8'h25});
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_state", {busy, in_ready, out_valid, out_byte, out_last, done, cf_out, af_out}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bp_hold = 1'b0;
        @(posedge clk); #1;

        // start pulsed while busy must not disturb the latched operation
        opa[0] = 8'h58; opb[0] = 8'h67; opa[1] = 8'h12; opb[1] = 8'h34;
        run_op(2'b11, 2, 1'b0, 1'b1, 0);

        // Randomised operations with stalls on both streams
        bp_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            m = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                if (m == 2'b11) begin
                    opa[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    opb[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                end else if (m == 2'b10) begin
                    opa[i] = 8'h30 + 8'($urandom_range(0, 9));
                    opb[i] = 8'h30 + 8'($urandom_range(0, 9));
                end else begin
                    opa[i] = 8'($urandom);
                    opb[i] = 8'($urandom);
                end
            end
            run_op(m, n, 1'($urandom_range(0, 1)), (n > 0) && ($urandom_range(0, 3) == 0), 2);
        end
        bp_rand = 1'b0;

        repeat (4) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("st_q_drained", st_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
